muxer_rr: RTL and testbench
===========================

Name: muxer_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes: manual, where an external select picks the channel, and round-robin, where an internal pointer rotates across the channels that have data.
- Sits between multiple producers and one consumer.
- Successor to the combinational 8:1 single-bit muxer.

Parameters:
- N_CH, 8, number of input channels (N_CH >= 2).
- W, 1, data width per channel in bits.
- SEL_W, $clog2(N_CH), width of the select input and of the channel tag (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational, at most one bit high.
- mode  input  1  0 = MODE_MANUAL, 1 = MODE_RR.
- sel  input  SEL_W  channel select; used only in MODE_MANUAL.
- out_data  output  W  registered data.
- out_ch  output  SEL_W  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (asynchronous, clk not required): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
- Reset takes effect mid-transfer; any held word is discarded.
- Output stage can load when load_ok = !out_valid | out_ready.

Grant, MODE_MANUAL:
- Candidate is sel.
- Grant is issued only if sel < N_CH and in_valid[sel]=1.
- sel >= N_CH gives no grant and all in_ready=0.

Grant, MODE_RR:
- Scan channels rr_ptr, rr_ptr+1, … modulo N_CH.
- Grant the first channel with in_valid high; no valid channel gives no grant.

Transfer and output register:
- in_ready[g] = load_ok for the granted channel g; all other bits are 0.
- Input transfer occurs on in_valid[g] & in_ready[g].
- On an input transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1. Latency is one cycle.
- When out_valid & out_ready and there is no new grant: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same cycle, giving full throughput of one word per cycle.
- While out_valid=1 and out_ready=0, out_data and out_ch are stable and all in_ready=0.

Round-robin pointer:
- On an input transfer in MODE_RR: rr_ptr <= g+1, wrapping from N_CH-1 to 0.
- In MODE_MANUAL rr_ptr holds.

Mode and select changes:
- A mode change takes effect on the next grant evaluation.
- A word already in the output register is unaffected.
- A sel change while stalled only redirects the next grant.

Input rule:
- Inputs must hold data while valid and not ready.
- The block never drops a word that has been accepted.

Optional Feature:
- Macro: MUXER_RR_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, 16 bits.
  - Counts output transfers (out_valid & out_ready) and saturates at 16'hFFFF.
  - Asynchronous reset to 0.
  - Adds input port cnt_clr, 1 bit; synchronous clear with priority over increment.
- Not defined: neither port exists and there is no counter logic.

Decomposition:
- Package muxer_pkg holds:
  - typedef enum logic {MODE_MANUAL=1'b0, MODE_RR=1'b1} mux_mode_t.
  - localparam CNT_W=16.
- Sub-module rr_arbiter:
  - Parameter N_CH.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_vld, gnt_idx[SEL_W].
  - Purely combinational rotate-priority encoder.
  - Instantiated once; rr_ptr stays in muxer_rr.

Test Plan:
- N_CH=8, W=8, MODE_MANUAL:
  - sel=3, in_valid=8'h08, in_data ch3=8'hA5, out_ready=1 -> in_ready=8'h08; next cycle out_valid=1, out_data=8'hA5, out_ch=3.
  - sel=7 with in_valid[7]=0 -> no transfer, all in_ready=0.
- Backpressure: load 8'h11 from ch0, hold out_ready=0 for 5 cycles -> out_data stays 8'h11, in_ready=0 throughout. Raise out_ready with ch1=8'h22 valid -> drain and load in the same cycle; next cycle out_data=8'h22.
- MODE_RR, all 8 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,…,7,0 with one transfer per cycle.
- MODE_RR, in_valid=8'b1000_0100, rr_ptr=3 -> grant ch7, then ch2, then ch7.
- Reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid drops immediately, out_data=0, out_ch=0. After release, the first RR grant starts from ch0.
- With MUXER_RR_CNT_EN: 70000 back-to-back transfers -> xfer_cnt=16'hFFFF. Pulse cnt_clr concurrently with a transfer -> xfer_cnt=0.

Source files
------------

// File: rtl/muxer_pkg.sv
// Shared types and constants for the muxer_rr N-channel registered multiplexer.
package muxer_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_t;

  localparam int CNT_W = 16;

endpackage : muxer_pkg

// File: rtl/muxer_rr_arbiter.sv
// Combinational rotate-priority encoder: first requester at or after ptr (mod N_CH) wins.
module rr_arbiter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  int               idx_int;
  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx_int = 0;
    idx     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx_int = (int'(ptr) + k) % N_CH;
      idx     = SEL_W'(idx_int);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/muxer_rr.sv
// N-channel registered mux with valid/ready handshakes, manual or round-robin selection.
// Optional transfer counter enabled by defining MUXER_RR_CNT_EN.
module muxer_rr
  import muxer_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUXER_RR_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  mux_mode_t        mode_e;
  logic [W-1:0]     ch_data [N_CH];

  logic             load_ok;
  logic             sel_in_range;
  logic             man_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;
  logic [N_CH-1:0]  in_ready_c;

  logic [W-1:0]     out_data_d,  out_data_q;
  logic [SEL_W-1:0] out_ch_d,    out_ch_q;
  logic             out_valid_d, out_valid_q;
  logic [SEL_W-1:0] rr_ptr_d,    rr_ptr_q;

  assign mode_e = mux_mode_t'(mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Grant selection: manual select is honoured only when it names a real, valid channel.
  always_comb begin
    load_ok      = !out_valid_q || out_ready;
    sel_in_range = (int'(sel) < N_CH);
    man_vld      = sel_in_range && in_valid[sel];
    gnt_vld      = 1'b0;
    gnt_idx      = '0;
    if (mode_e == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = man_vld;
      gnt_idx = sel;
    end
    xfer       = gnt_vld && load_ok;
    in_ready_c = '0;
    if (gnt_vld) begin
      in_ready_c[gnt_idx] = load_ok;
    end
  end

  assign in_ready = in_ready_c;

  // Output register and pointer next-state.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt_idx];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode_e == MODE_RR) begin
        rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef MUXER_RR_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_d, xfer_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Clear wins over a coincident output transfer.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (cnt_clr) begin
      xfer_cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      xfer_cnt_d = sat_inc(xfer_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule : muxer_rr

// File: tb/tb_muxer_rr.sv
// Directed self-checking bench for muxer_rr (N_CH=8, W=8); counter checks when MUXER_RR_CNT_EN is set.
module tb_muxer_rr;

  localparam int N_CH  = 8;
  localparam int W     = 8;
  localparam int SEL_W = 3;

  logic              clk;
  logic              rst_n;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;
`ifdef MUXER_RR_CNT_EN
  logic              cnt_clr;
  logic [15:0]       xfer_cnt;
`endif

  int tests;
  int failed;

  muxer_rr #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUXER_RR_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, required $finish before 5000000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SEL_W-1:0] exp_ch;
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
`ifdef MUXER_RR_CNT_EN
    cnt_clr   = 1'b0;
`endif

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Manual select of channel 3
    mode      = 1'b0;
    sel       = 3'd3;
    in_valid  = 8'h08;
    in_data   = 64'h0000_0000_A500_0000;
    out_ready = 1'b1;
    #1;
    chk("man_in_ready", 32'(in_ready), 32'h08);
    tick();
    chk("man_out_valid", 32'(out_valid), 32'd1);
    chk("man_out_data",  32'(out_data),  32'hA5);
    chk("man_out_ch",    32'(out_ch),    32'd3);
    in_valid = 8'h00;
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_data", 32'(out_data),  32'hA5);

    // Selected channel not valid while others are
    sel      = 3'd7;
    in_valid = 8'h7F;
    #1;
    chk("sel7_in_ready", 32'(in_ready), 32'h00);
    tick();
    chk("sel7_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: load ch0, stall five cycles, then drain+load ch1
    sel       = 3'd0;
    in_valid  = 8'h01;
    in_data   = 64'h0000_0000_0000_2211;
    out_ready = 1'b0;
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'h01);
    tick();
    chk("bp_load_data", 32'(out_data), 32'h11);
    in_valid = 8'h02;
    sel      = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_ready", 32'(in_ready), 32'h00);
      tick();
      chk("bp_stall_data",  32'(out_data),  32'h11);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h02);
    tick();
    chk("bp_swap_data",  32'(out_data),  32'h22);
    chk("bp_swap_ch",    32'(out_ch),    32'd1);
    chk("bp_swap_valid", 32'(out_valid), 32'd1);

    // Round-robin over all channels, pointer starts at 0
    mode     = 1'b1;
    in_valid = 8'hFF;
    in_data  = 64'h3736_3534_3332_3130;
    for (int i = 0; i < 9; i++) begin
      exp_ch = SEL_W'(i % N_CH);
      tick();
      chk("rr_all_ch",    32'(out_ch),    32'(exp_ch));
      chk("rr_all_data",  32'(out_data),  32'h30 + 32'(exp_ch));
      chk("rr_all_valid", 32'(out_valid), 32'd1);
    end

    // Pointer is 1; a lone grant on ch2 moves it to 3
    in_valid = 8'h04;
    tick();
    chk("rr_ptr3_ch", 32'(out_ch), 32'd2);
    in_valid = 8'h84;
    tick();
    chk("rr_sparse_1", 32'(out_ch), 32'd7);
    tick();
    chk("rr_sparse_2", 32'(out_ch), 32'd2);
    tick();
    chk("rr_sparse_3", 32'(out_ch), 32'd7);
    tick();
    chk("rr_sparse_4", 32'(out_ch), 32'd2);

    // Asynchronous reset between edges with a word held (pointer now 3)
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_out_ch",    32'(out_ch),    32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 8'hFF;
    #1;
    chk("arst_rr_ready", 32'(in_ready), 32'h01);
    tick();
    chk("arst_rr_ch", 32'(out_ch), 32'd0);

`ifdef MUXER_RR_CNT_EN
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    chk("cnt_saturate", 32'(xfer_cnt), 32'hFFFF);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clear", 32'(xfer_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("cnt_after_clear", 32'(xfer_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_muxer_rr
